// File: rtl/demux_1x2_reg.sv
// rtl/demux_1x2_reg.sv - registered 1:2 demux, one holding slot per output channel.
// Optional drain counters (out0_count/out1_count) exist only when DEMUX_COUNT_EN is defined.
module demux_1x2_reg #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
`ifdef DEMUX_COUNT_EN
  ,
  output logic [7:0]       out0_count,
  output logic [7:0]       out1_count
`endif
);

  logic             out0_valid_q, out0_valid_d;
  logic             out1_valid_q, out1_valid_d;
  logic [WIDTH-1:0] out0_data_q, out0_data_d;
  logic [WIDTH-1:0] out1_data_q, out1_data_d;

  logic slot0_free, slot1_free;
  logic accept, load0, load1;

  // A slot can take a word when it is empty or being drained on this same edge.
  assign slot0_free = ~out0_valid_q | out0_ready;
  assign slot1_free = ~out1_valid_q | out1_ready;

  assign in_ready = sel ? slot1_free : slot0_free;
  assign accept   = in_valid & in_ready;
  assign load0    = accept & ~sel;
  assign load1    = accept & sel;

  always_comb begin
    out0_valid_d = out0_valid_q;
    out1_valid_d = out1_valid_q;
    out0_data_d  = out0_data_q;
    out1_data_d  = out1_data_q;

    if (load0) begin
      out0_valid_d = 1'b1;
      out0_data_d  = in_data;
    end else if (out0_ready) begin
      out0_valid_d = 1'b0;
    end

    if (load1) begin
      out1_valid_d = 1'b1;
      out1_data_d  = in_data;
    end else if (out1_ready) begin
      out1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out0_valid_q <= 1'b0;
      out1_valid_q <= 1'b0;
      out0_data_q  <= '0;
      out1_data_q  <= '0;
    end else begin
      out0_valid_q <= out0_valid_d;
      out1_valid_q <= out1_valid_d;
      out0_data_q  <= out0_data_d;
      out1_data_q  <= out1_data_d;
    end
  end

  assign out0_valid = out0_valid_q;
  assign out1_valid = out1_valid_q;
  assign out0_data  = out0_data_q;
  assign out1_data  = out1_data_q;

`ifdef DEMUX_COUNT_EN
  logic [7:0] out0_count_q, out0_count_d;
  logic [7:0] out1_count_q, out1_count_d;
  logic       drain0, drain1;

  assign drain0 = out0_valid_q & out0_ready;
  assign drain1 = out1_valid_q & out1_ready;

  // Counters wrap naturally at 8 bits.
  always_comb begin
    out0_count_d = out0_count_q + {7'd0, drain0};
    out1_count_d = out1_count_q + {7'd0, drain1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out0_count_q <= 8'd0;
      out1_count_q <= 8'd0;
    end else begin
      out0_count_q <= out0_count_d;
      out1_count_q <= out1_count_d;
    end
  end

  assign out0_count = out0_count_q;
  assign out1_count = out1_count_q;
`endif

endmodule

// File: doc/demux_1x2_reg.md
# demux_1x2_reg

Registered 1-to-2 demultiplexer with valid/ready handshakes: the routing counterpart of the team's 2:1 multiplexer. One input stream of WIDTH-bit words is steered, per word, by `sel` to one of two output channels. Each channel holds one registered slot, so the two consumers can stall independently. The block sits where a shared bus fans out to two downstream consumers.

## Interface
- `WIDTH`, default 2: data width of input and both outputs.
- `clk` in 1: single clock; everything is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input word present.
- `in_ready` out 1: block accepts the input word this cycle.
- `in_data` in WIDTH: input word.
- `sel` in 1: destination of the input word; 0 routes to out0, 1 routes to out1. Sampled with `in_data`.
- `out0_valid` out 1: out0 slot holds a word.
- `out0_ready` in 1: consumer 0 takes the word.
- `out0_data` out WIDTH: out0 slot contents.
- `out1_valid` out 1: out1 slot holds a word.
- `out1_ready` in 1: consumer 1 takes the word.
- `out1_data` out WIDTH: out1 slot contents.
- `out0_count` out 8: present only with DEMUX_COUNT_EN. Number of words delivered on out0.
- `out1_count` out 8: present only with DEMUX_COUNT_EN. Number of words delivered on out1.

## Operation
- Each output N has a one-entry slot with two states: EMPTY (`outN_valid`=0) and FULL (`outN_valid`=1).
- Accept condition: `in_valid & in_ready`.
- `in_ready` is combinational: `sel ? (~out1_valid | out1_ready) : (~out0_valid | out0_ready)`. It depends only on the selected slot.
- On accept, the selected slot loads `in_data` and is FULL next cycle.
- The unselected slot is never written by an accept. Its state changes only through its own drain.
- Drain condition for N: `outN_valid & outN_ready`.
  - Drain with no load: slot goes EMPTY next cycle.
  - Drain and load on the same edge: slot stays FULL with the new data.
- EMPTY slot with `outN_ready`=1: nothing happens.
- `outN_data` holds its last value while EMPTY. Consumers must qualify it with `outN_valid`.
- Order is preserved within each channel. There is no ordering guarantee between channels.
- Words are never dropped or duplicated.
- `in_valid` high with `in_ready` low: the block does nothing. The upstream holds `in_data` and `sel` stable until acceptance.

## Timing
- Latency is 1 cycle: a word accepted at edge k is visible on `outN_data`/`outN_valid` after edge k.
- Throughput:
  - 1 word/cycle into a channel whose consumer holds ready high.
  - Alternating `sel` sustains 1 word/cycle even when each consumer accepts only every other cycle.
- Reset values (synchronous, applied at the next edge with `rst`=1):
  - `out0_valid`=0, `out1_valid`=0.
  - `out0_data`=0, `out1_data`=0.
  - Counters=0.
- `rst` takes priority over accept and drain in the same cycle.
- Reset mid-operation discards any held words.
- `in_ready` during reset is evaluated from the pre-reset slot state. Upstream must not rely on transfers made during an `rst`=1 cycle; those transfers are lost.
- Simultaneous drains of out0 and out1 with an accept into either slot are all legal in one cycle.

## Configuration
- `DEMUX_COUNT_EN` defined:
  - `out0_count`/`out1_count` ports and registers exist.
  - Each counter increments by 1 on every drain of its channel.
  - Counters wrap from 255 to 0 and clear on `rst`.
- `DEMUX_COUNT_EN` undefined: counter ports and logic are absent. Routing behaviour is identical.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `in_valid`=1 → both valids 0, both data 0, counters 0 after release.
- Basic routing, WIDTH=2, both readies held 1: send 2'b01 with sel=0, then 2'b11 with sel=1 → `out0_data`=01 valid one cycle after the first accept; `out1_data`=11 valid one cycle after the second accept; no cross-writes.
- Backpressure isolation: `out0_ready`=0, send 2'b10 with sel=0, then 2'b01 with sel=0, then 2'b11 with sel=1 →
  - first word held in out0;
  - second word stalls (`in_ready`=0) until `out0_ready` rises;
  - the sel=1 word is accepted once it reaches the input, without waiting on out0.
- Pass-through at full rate: out0 FULL with 2'b00, `out0_ready`=1, same-cycle accept of 2'b11 with sel=0 → `out0_valid` stays 1 and `out0_data`=11 next cycle; count increments once.
- Reset mid-stream: both slots FULL, assert `rst` for 1 cycle with `out1_ready`=1 → both valids 0 next cycle; `out1_count` unchanged from its reset value.
- With `DEMUX_COUNT_EN`: 257 drains on out1 → `out1_count`=1, `out0_count`=0.
